i2c_sclgen: RTL
===============

Name: i2c_sclgen

Overview:
Parameterised SCL waveform generator for the I2C master; next generation of the fixed 6-bit high/low clock divider. Generates the full SCL high/low cycle from programmable high and low counts of width CNT_W, behind a programmable prescaler. Adds shadowed count registers applied only at period boundaries, slave clock-stretch detection, and single-cycle edge strobes. Sits between the register interface (count writes) and the bit-level I2C controller (edge strobes, SCL drive).

Parameters:
CNT_W, 8, width of the high and low phase counts
PRE_W, 4, width of the prescaler reload value
RST_HI, 8'h30, reset value of the high count (CNT_W bits)
RST_LO, 8'h30, reset value of the low count (CNT_W bits)

Ports:
clk  input  1  system clock; all state is on posedge
rst_ap  input  1  asynchronous, active-high reset
en  input  1  run the generator; 0 parks SCL high
writeHi  input  1  load data into pending high count
writeLo  input  1  load data into pending low count
data  input  CNT_W  new count value from the register bus
prescale  input  PRE_W  prescaler reload value; tick every prescale+1 clocks
scl_line  input  1  synchronised SCL pad level (1 = released/high)
loadValHi  output  CNT_W  pending high count (readback)
loadValLo  output  CNT_W  pending low count (readback)
scl_hi  output  1  generated SCL phase (1 = release line)
rise  output  1  one-cycle strobe in the cycle scl_hi becomes 1
fall  output  1  one-cycle strobe in the cycle scl_hi becomes 0
stretching  output  1  high phase frozen by a low SCL line

Behaviour:
- Reset (rst_ap=1, asynchronous): pending and active counts = RST_HI/RST_LO; state IDLE; cnt=0; pcnt=0; scl_hi=1; rise=fall=stretching=0.
- Pending registers: writeHi/writeLo load data on the next posedge; otherwise hold. loadValHi/Lo reflect pending.
- Active registers: copy pending on IDLE->LOW and on every HIGH->LOW transition.
  - A write in the same cycle as a boundary does not reach active; active takes the old pending value and the new write applies at the next boundary.
- States: IDLE, LOW, HIGH. All outputs are registered.
- IDLE:
  - scl_hi=1.
  - On a clock with en=1: go to LOW, scl_hi=0, fall=1, cnt=active lo (after the copy), pcnt=prescale.
- Prescaler:
  - In LOW/HIGH, tick = (pcnt==0).
  - On tick, pcnt reloads prescale; otherwise pcnt decrements.
  - prescale=0 gives a tick every cycle.
- LOW:
  - On tick with cnt!=0: cnt decrements.
  - On tick with cnt==0: go to HIGH, scl_hi=1, rise=1, cnt=active hi.
  - LOW lasts (prescale+1)*(lo+1) clocks.
- HIGH with scl_line=0 (stretch):
  - stretching=1; cnt frozen; pcnt held at prescale.
  - No timeout is applied.
- HIGH with scl_line=1:
  - stretching=0.
  - On tick with cnt!=0: cnt decrements.
  - On tick with cnt==0: go to LOW, scl_hi=0, fall=1, active copy, cnt=new active lo.
  - Unstretched HIGH lasts (prescale+1)*(hi+1) clocks.
  - Unstretched period is (prescale+1)*(hi+lo+2) clocks.
- en=0 in LOW or HIGH:
  - Next clock goes to IDLE, scl_hi=1, stretching=0.
  - rise=1 only if scl_hi was 0.
- Count value 0 is legal and gives a one-tick phase. Counts never wrap; reload happens only at 0.
- prescale changes take effect at the next pcnt reload.
- rise and fall are never both 1 in the same cycle.

Test Plan:
- Reset, then read loadValHi/Lo -> both 8'h30; scl_hi=1, rise=fall=stretching=0.
- prescale=0, hi=3, lo=4, en=1, scl_line=1 -> scl_hi low 5 clocks, high 4 clocks, period 9; fall/rise single-cycle at each edge.
- prescale=1, hi=0, lo=0 -> scl_hi low 2 clocks, high 2 clocks; prescale=3, hi=lo=0 -> period 8.
- hi=3, lo=4, prescale=0; hold scl_line=0 for 6 clocks after rise -> stretching=1 for those 6 clocks; scl_hi high 10 clocks total; next fall on schedule.
- Write lo=1 mid-LOW, and also in the exact HIGH->LOW boundary cycle -> current low phase unchanged; new value used from the next low phase (one period later for the boundary write).
- en=0 mid-LOW -> rise strobe, IDLE, scl_hi=1. Assert rst_ap mid-HIGH -> immediate (asynchronous) return to reset values; counts revert to 8'h30.

Source files
------------

// File: rtl/i2c_sclgen.sv
// SCL waveform generator: programmable high/low phase counts behind a prescaler,
// shadowed count registers, clock-stretch detection and single-cycle edge strobes.
module i2c_sclgen #(
    parameter int               CNT_W  = 8,
    parameter int               PRE_W  = 4,
    parameter logic [CNT_W-1:0] RST_HI = 8'h30,
    parameter logic [CNT_W-1:0] RST_LO = 8'h30
) (
    input  logic             clk,
    input  logic             rst_ap,
    input  logic             en,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [CNT_W-1:0] data,
    input  logic [PRE_W-1:0] prescale,
    input  logic             scl_line,
    output logic [CNT_W-1:0] loadValHi,
    output logic [CNT_W-1:0] loadValLo,
    output logic             scl_hi,
    output logic             rise,
    output logic             fall,
    output logic             stretching
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_pend_hi;
    logic [CNT_W-1:0] r_pend_lo;
    logic [CNT_W-1:0] r_act_hi;
    logic [CNT_W-1:0] r_act_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PRE_W-1:0] r_pcnt;
    logic [PRE_W-1:0] w_pcnt_nxt;
    logic             w_copy;
    logic             w_tick;
    logic             r_scl_hi;
    logic             r_rise;
    logic             r_fall;
    logic             r_stretching;
    logic             w_scl_hi_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_stretch_nxt;

    // State, counters, count registers and registered outputs.
    always_ff @(posedge clk or posedge rst_ap) begin
        if (rst_ap) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_pcnt       <= {PRE_W{1'b0}};
            r_pend_hi    <= RST_HI;
            r_pend_lo    <= RST_LO;
            r_act_hi     <= RST_HI;
            r_act_lo     <= RST_LO;
            r_scl_hi     <= 1'b1;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_stretching <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_scl_hi     <= w_scl_hi_nxt;
            r_rise       <= w_rise_nxt;
            r_fall       <= w_fall_nxt;
            r_stretching <= w_stretch_nxt;
            // Active takes the pre-write pending value, so a same-cycle write waits a period.
            if (w_copy) begin
                r_act_hi <= r_pend_hi;
                r_act_lo <= r_pend_lo;
            end else begin
                r_act_hi <= r_act_hi;
                r_act_lo <= r_act_lo;
            end
            if (writeHi) begin
                r_pend_hi <= data;
            end else begin
                r_pend_hi <= r_pend_hi;
            end
            if (writeLo) begin
                r_pend_lo <= data;
            end else begin
                r_pend_lo <= r_pend_lo;
            end
        end
    end

    // Next state, phase counter and prescaler.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_copy      = 1'b0;
        w_tick      = (r_pcnt == {PRE_W{1'b0}});
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_LOW;
                    w_copy      = 1'b1;
                    w_cnt_nxt   = r_pend_lo;
                    w_pcnt_nxt  = prescale;
                end else begin
                    w_cnt_nxt  = {CNT_W{1'b0}};
                    w_pcnt_nxt = {PRE_W{1'b0}};
                end
            end
            ST_LOW: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_pcnt_nxt  = {PRE_W{1'b0}};
                end else if (w_tick) begin
                    w_pcnt_nxt = prescale;
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = r_act_hi;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt - PRE_W'(1);
                end
            end
            ST_HIGH: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_pcnt_nxt  = {PRE_W{1'b0}};
                end else if (!scl_line) begin
                    // Slave holds SCL low: freeze the phase and restart the current tick.
                    w_pcnt_nxt = prescale;
                end else if (w_tick) begin
                    w_pcnt_nxt = prescale;
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_copy      = 1'b1;
                        w_cnt_nxt   = r_pend_lo;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt - PRE_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_pcnt_nxt  = {PRE_W{1'b0}};
            end
        endcase
    end

    // Output values registered alongside the state transition.
    always_comb begin
        w_scl_hi_nxt  = (w_state_nxt != ST_LOW);
        w_rise_nxt    = (r_state == ST_LOW) && (w_state_nxt != ST_LOW);
        w_fall_nxt    = (r_state != ST_LOW) && (w_state_nxt == ST_LOW);
        w_stretch_nxt = (r_state == ST_HIGH) && en && !scl_line;
    end

    assign loadValHi  = r_pend_hi;
    assign loadValLo  = r_pend_lo;
    assign scl_hi     = r_scl_hi;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign stretching = r_stretching;

endmodule
